// File: rtl/arm_pkg.sv
// Shared constants for the multi-axis arm stepper: register map, mode fields,
// step FSM encoding and the speed-to-magnitude helper.
package arm_pkg;

    localparam logic [7:0] ARM_SPEED_BASE  = 8'h00;
    localparam logic [7:0] ARM_STATUS_ADDR = 8'hF0;
    localparam logic [7:0] SPEED_STOP      = 8'd127;

    localparam int MODE_USTEP_LSB = 0;
    localparam int MODE_USTEP_MSB = 2;
    localparam int MODE_EN_BIT    = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Offset-binary speed to unsigned magnitude: 0 -> 127, 127 -> 0, 255 -> 128.
    function automatic logic [7:0] speedMagnitude(input logic [7:0] speed);
        return (speed > SPEED_STOP) ? (speed - SPEED_STOP) : (SPEED_STOP - speed);
    endfunction

endpackage

// File: rtl/arm_step_gen.sv
// One stepper axis: phase accumulator, direction hold-off and the
// fixed-width step pulse sequencer (high time, then equal low time).
module arm_step_gen
    import arm_pkg::*;
#(
    parameter int ACC_W     = 12,
    parameter int STEP_HIGH = 24,
    parameter int DIR_SETUP = 12
) (
    input  logic       clk_12MHz,
    input  logic       reset,
    input  logic       tick_i,
    input  logic [7:0] m_i,
    input  logic       dirReq_i,
    input  logic       allowed_i,
    output logic       step_o,
    output logic       dir_o
);

    localparam int CNT_W   = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
    localparam int SETUP_W = $clog2(DIR_SETUP + 1);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SETUP_W-1:0] setup_q, setup_d;
    logic               dir_q, dir_d;
    logic [ACC_W:0]     accSum;
    logic               stepReq;

    assign accSum  = {1'b0, acc_q} + (ACC_W + 1)'(m_i);
    assign stepReq = tick_i & accSum[ACC_W];

    // Requests that land outside IDLE, or during the direction hold-off, are dropped.
    always_comb begin
        acc_d   = acc_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        setup_d = (setup_q != '0) ? (setup_q - 1'b1) : setup_q;
        if (tick_i) begin
            acc_d = accSum[ACC_W-1:0];
        end
        case (state_q)
            ST_IDLE: begin
                if (dirReq_i != dir_q) begin
                    dir_d   = dirReq_i;
                    setup_d = SETUP_W'(DIR_SETUP);
                end else if (stepReq && allowed_i && (setup_q == '0)) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end
            end
            ST_HIGH: begin
                if (cnt_q == CNT_W'(STEP_HIGH - 1)) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_LOW: begin
                if (cnt_q == CNT_W'(STEP_HIGH - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            acc_q   <= '0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            setup_q <= '0;
            dir_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            setup_q <= setup_d;
            dir_q   <= dir_d;
        end
    end

    assign step_o = (state_q == ST_HIGH);
    assign dir_o  = dir_q;

endmodule

// File: rtl/arm_multi_axis_stepper.sv
// N-axis stepper peripheral on the uniboard register bus: register file,
// 100 kHz tick prescaler, input synchronisers, fault/limit interlocks.
module arm_multi_axis_stepper
    import arm_pkg::*;
#(
    parameter int N_AXES    = 4,
    parameter int PRESCALE  = 120,
    parameter int ACC_W     = 12,
    parameter int STEP_HIGH = 24,
    parameter int DIR_SETUP = 12
) (
    input  logic                  clk_12MHz,
    input  logic                  reset,
    inout  wire  [31:0]           databus,
    output logic [2:0]            reg_size,
    input  logic [7:0]            register_addr,
    input  logic                  rw,
    input  logic                  select,
    input  logic                  pause,
    output logic [3*N_AXES-1:0]   microstep,
    output logic [N_AXES-1:0]     step,
    output logic [N_AXES-1:0]     dir,
    output logic [N_AXES-1:0]     en,
    input  logic [N_AXES-1:0]     fault,
    input  logic [N_AXES-1:0]     limitn
);

    localparam int PRE_W = $clog2(PRESCALE);

    logic [7:0]        speed_q [N_AXES];
    logic [7:0]        speed_d [N_AXES];
    logic [3:0]        mode_q  [N_AXES];
    logic [3:0]        mode_d  [N_AXES];
    logic              selectPrev_q;
    logic [31:0]       readValue_q, readValue_d;
    logic [2:0]        readSize_q, readSize_d;
    logic [PRE_W-1:0]  preCnt_q;
    logic [N_AXES-1:0] faultMeta_q, faultSync_q;
    logic [N_AXES-1:0] limitMeta_q, limitSync_q;
    logic [N_AXES-1:0] sticky_q, sticky_d;
    logic [N_AXES-1:0] en_q, en_d;
    logic [N_AXES-1:0] clearMask;
    logic [31:0]       statusWord;
    logic              selRise;
    logic              tick;

    assign selRise = select & ~selectPrev_q;
    assign tick    = (preCnt_q == PRE_W'(PRESCALE - 1));

    always_comb begin
        statusWord                = '0;
        statusWord[N_AXES-1:0]    = sticky_q;
        statusWord[N_AXES+7:8]    = limitSync_q;
    end

    // Reads latch the pre-write value; writes commit bus data on the same edge.
    always_comb begin
        speed_d     = speed_q;
        mode_d      = mode_q;
        readValue_d = readValue_q;
        readSize_d  = readSize_q;
        clearMask   = '0;
        if (selRise) begin
            readValue_d = '0;
            readSize_d  = '0;
            for (int i = 0; i < N_AXES; i++) begin
                if (register_addr == ARM_SPEED_BASE + 8'(2 * i)) begin
                    readSize_d  = 3'd1;
                    readValue_d = {24'b0, speed_q[i]};
                    if (!rw) begin
                        speed_d[i] = databus[7:0];
                    end
                end else if (register_addr == ARM_SPEED_BASE + 8'(2 * i + 1)) begin
                    readSize_d  = 3'd1;
                    readValue_d = {28'b0, mode_q[i]};
                    if (!rw) begin
                        mode_d[i] = databus[3:0];
                    end
                end
            end
            if (register_addr == ARM_STATUS_ADDR) begin
                readSize_d  = 3'd2;
                readValue_d = statusWord;
                if (!rw) begin
                    clearMask = databus[N_AXES-1:0];
                end
            end
        end
    end

    // A fault seen in the same cycle as a write-1-to-clear keeps the sticky bit set.
    always_comb begin
        sticky_d = (sticky_q & ~clearMask) | faultSync_q;
        for (int i = 0; i < N_AXES; i++) begin
            en_d[i] = mode_q[i][MODE_EN_BIT] & ~sticky_q[i] & ~faultSync_q[i];
        end
    end

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            selectPrev_q <= 1'b0;
            readValue_q  <= '0;
            readSize_q   <= '0;
            preCnt_q     <= '0;
            faultMeta_q  <= '0;
            faultSync_q  <= '0;
            limitMeta_q  <= '0;
            limitSync_q  <= '0;
            sticky_q     <= '0;
            en_q         <= '0;
            for (int i = 0; i < N_AXES; i++) begin
                speed_q[i] <= SPEED_STOP;
                mode_q[i]  <= '0;
            end
        end else begin
            selectPrev_q <= select;
            readValue_q  <= readValue_d;
            readSize_q   <= readSize_d;
            preCnt_q     <= tick ? '0 : (preCnt_q + 1'b1);
            faultMeta_q  <= fault;
            faultSync_q  <= faultMeta_q;
            limitMeta_q  <= ~limitn;
            limitSync_q  <= limitMeta_q;
            sticky_q     <= sticky_d;
            en_q         <= en_d;
            for (int i = 0; i < N_AXES; i++) begin
                speed_q[i] <= speed_d[i];
                mode_q[i]  <= mode_d[i];
            end
        end
    end

    assign databus  = (select && rw) ? readValue_q : 32'bz;
    assign reg_size = select ? readSize_q : 3'bz;
    assign en       = en_q;

    // Pause gates the tick so each accumulator freezes in place.
    for (genvar g = 0; g < N_AXES; g++) begin : g_axis
        logic [7:0] mag;
        logic       dirReq;
        logic       allowed;

        assign mag     = speedMagnitude(speed_q[g]);
        assign dirReq  = speed_q[g] > SPEED_STOP;
        assign allowed = en_q[g] & ~pause & ~(limitSync_q[g] & ~dirReq) & (mag != 8'd0);
        assign microstep[3*g +: 3] = mode_q[g][MODE_USTEP_MSB:MODE_USTEP_LSB];

        arm_step_gen #(
            .ACC_W     (ACC_W),
            .STEP_HIGH (STEP_HIGH),
            .DIR_SETUP (DIR_SETUP)
        ) u_step_gen (
            .clk_12MHz (clk_12MHz),
            .reset     (reset),
            .tick_i    (tick & ~pause),
            .m_i       (mag),
            .dirReq_i  (dirReq),
            .allowed_i (allowed),
            .step_o    (step[g]),
            .dir_o     (dir[g])
        );
    end

endmodule

// File: tb/tb_arm_multi_axis_stepper.sv
// Directed bench for arm_multi_axis_stepper: bus accesses and step timing
// checked against a queue of expected results.
module tb_arm_multi_axis_stepper;

    localparam int N = 4;

    logic          clk_12MHz = 1'b0;
    logic          reset;
    wire  [31:0]   databus;
    wire  [2:0]    regSize;
    logic [7:0]    registerAddr;
    logic          rw;
    logic          select;
    logic          pause;
    wire  [3*N-1:0] microstep;
    wire  [N-1:0]  step;
    wire  [N-1:0]  dir;
    wire  [N-1:0]  en;
    logic [N-1:0]  fault;
    logic [N-1:0]  limitn;
    logic [31:0]   tbData;
    logic          tbOe;

    assign databus = tbOe ? tbData : 32'bz;

    always #5 clk_12MHz = ~clk_12MHz;

    int cyc = 0;
    always @(posedge clk_12MHz) cyc <= cyc + 1;

    arm_multi_axis_stepper dut (
        .clk_12MHz     (clk_12MHz),
        .reset         (reset),
        .databus       (databus),
        .reg_size      (regSize),
        .register_addr (registerAddr),
        .rw            (rw),
        .select        (select),
        .pause         (pause),
        .microstep     (microstep),
        .step          (step),
        .dir           (dir),
        .en            (en),
        .fault         (fault),
        .limitn        (limitn)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } expEntry_t;

    expEntry_t sbq[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic void expectPush(input string tag, input logic [31:0] val);
        expEntry_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endfunction

    task automatic checkOutput(input logic [31:0] observed);
        expEntry_t e;
        compared++;
        if (sbq.size() == 0) begin
            mismatched++;
            $error("[TB] FAIL scoreboard_empty: observed 0x%0h expected none", observed);
        end else begin
            e = sbq.pop_front();
            assert (observed === e.val) else begin
                mismatched++;
                $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", e.tag, observed, e.val);
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk_12MHz);
    endtask

    // One bus access; reads compare size then data against the queue head.
    task automatic applyStimulus(input logic [7:0] addr, input logic isRead, input logic [31:0] wdata);
        @(negedge clk_12MHz);
        registerAddr = addr;
        rw           = isRead;
        tbOe         = ~isRead;
        tbData       = wdata;
        select       = 1'b1;
        @(negedge clk_12MHz);
        if (isRead) begin
            checkOutput({29'b0, regSize});
            checkOutput(databus);
        end
        select = 1'b0;
        tbOe   = 1'b0;
        rw     = 1'b0;
    endtask

    task automatic busRead(input logic [7:0] addr, input logic [2:0] expSize,
                           input logic [31:0] expData, input string tag);
        expectPush({tag, "_size"}, {29'b0, expSize});
        expectPush({tag, "_data"}, expData);
        applyStimulus(addr, 1'b1, 32'h0);
    endtask

    function automatic logic sigOf(input int kind, input int axis);
        case (kind)
            0:       return step[axis];
            1:       return dir[axis];
            default: return en[axis];
        endcase
    endfunction

    task automatic waitLevel(input int kind, input int axis, input logic level, input int maxCyc,
                             output int t, output bit ok);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < maxCyc; i++) begin
            @(negedge clk_12MHz);
            if (sigOf(kind, axis) === level) begin
                ok = 1'b1;
                t  = cyc;
                break;
            end
        end
    endtask

    task automatic waitRise(input int axis, input int maxCyc, output int t, output bit ok);
        bit lowOk;
        waitLevel(0, axis, 1'b0, maxCyc, t, lowOk);
        waitLevel(0, axis, 1'b1, maxCyc, t, ok);
        ok = ok & lowOk;
    endtask

    initial begin
        int r1, r2, r3, f1, f2, d, p0, p1, delta;
        bit ok;

        reset        = 1'b1;
        select       = 1'b0;
        rw           = 1'b0;
        registerAddr = 8'h00;
        pause        = 1'b0;
        fault        = '0;
        limitn       = '1;
        tbOe         = 1'b0;
        tbData       = '0;
        waitCycles(3);
        reset = 1'b0;
        @(negedge clk_12MHz);

        $display("[TB] reset state and register map");
        expectPush("rst_step", 32'h0);
        expectPush("rst_en", 32'h0);
        expectPush("rst_dir", 32'h0);
        expectPush("rst_microstep", 32'h0);
        checkOutput(32'(step));
        checkOutput(32'(en));
        checkOutput(32'(dir));
        checkOutput(32'(microstep));
        busRead(8'h00, 3'd1, 32'd127, "t1_speed0");
        busRead(8'h01, 3'd1, 32'd0, "t1_mode0");
        busRead(8'h55, 3'd0, 32'd0, "t1_bad_addr");
        busRead(8'hF0, 3'd2, 32'h0, "t1_status");

        $display("[TB] full forward on axis 0, mode field masking on axis 2");
        applyStimulus(8'h01, 1'b0, 32'h08);
        applyStimulus(8'h00, 1'b0, 32'hFF);
        applyStimulus(8'h05, 1'b0, 32'hF5);
        busRead(8'h05, 3'd1, 32'h05, "t2_mode2_rb");
        busRead(8'h00, 3'd1, 32'hFF, "t2_speed0_rb");
        expectPush("t2_microstep2", 32'd5);
        expectPush("t2_en", 32'b0001);
        expectPush("t2_rise0_seen", 32'd1);
        expectPush("t2_dir0", 32'd1);
        expectPush("t2_width0", 32'd24);
        expectPush("t2_rise1_seen", 32'd1);
        expectPush("t2_period0", 32'd3840);
        expectPush("t2_width1", 32'd24);
        expectPush("t2_rise2_seen", 32'd1);
        expectPush("t2_period1", 32'd3840);
        checkOutput(32'(microstep[8:6]));
        checkOutput(32'(en));
        waitRise(0, 4500, r1, ok);
        checkOutput({31'b0, ok});
        checkOutput({31'b0, dir[0]});
        waitLevel(0, 0, 1'b0, 100, f1, ok);
        checkOutput(32'(f1 - r1));
        waitRise(0, 4500, r2, ok);
        checkOutput({31'b0, ok});
        checkOutput(32'(r2 - r1));
        waitLevel(0, 0, 1'b0, 100, f2, ok);
        checkOutput(32'(f2 - r2));
        waitRise(0, 4500, r3, ok);
        checkOutput({31'b0, ok});
        checkOutput(32'(r3 - r2));

        $display("[TB] reversal during a pulse");
        applyStimulus(8'h00, 1'b0, 32'd191);
        expectPush("t3_rise_seen", 32'd1);
        waitRise(0, 8500, r1, ok);
        checkOutput({31'b0, ok});
        waitCycles(3);
        applyStimulus(8'h00, 1'b0, 32'd0);
        expectPush("t3_width", 32'd24);
        expectPush("t3_dir_after_low", 32'd1);
        expectPush("t3_rise_after_setup", 32'd1);
        expectPush("t3_dir_reverse", 32'd0);
        waitLevel(0, 0, 1'b0, 100, f1, ok);
        checkOutput(32'(f1 - r1));
        waitLevel(1, 0, 1'b0, 200, d, ok);
        checkOutput({31'b0, ok && (d - r1 >= 48) && (d - r1 <= 60)});
        waitLevel(0, 0, 1'b1, 5000, r2, ok);
        checkOutput({31'b0, ok && (r2 - d >= 12)});
        checkOutput({31'b0, dir[0]});

        $display("[TB] limit switch blocks reverse only");
        limitn[0] = 1'b0;
        expectPush("t4_width", 32'd24);
        expectPush("t4_blocked", 32'd0);
        waitLevel(0, 0, 1'b0, 100, f1, ok);
        checkOutput(32'(f1 - r2));
        waitLevel(0, 0, 1'b1, 4500, r1, ok);
        checkOutput({31'b0, ok});
        busRead(8'hF0, 3'd2, 32'h0000_0100, "t4_status");
        applyStimulus(8'h00, 1'b0, 32'd200);
        expectPush("t4_resume", 32'd1);
        expectPush("t4_dir_fwd", 32'd1);
        waitLevel(0, 0, 1'b1, 7500, r1, ok);
        checkOutput({31'b0, ok});
        checkOutput({31'b0, dir[0]});
        limitn[0] = 1'b1;

        $display("[TB] pause mid-pulse and phase retention");
        applyStimulus(8'h00, 1'b0, 32'hFF);
        expectPush("t5_rise_seen", 32'd1);
        expectPush("t5_width", 32'd24);
        expectPush("t5_paused_no_step", 32'd0);
        waitRise(0, 4500, r1, ok);
        checkOutput({31'b0, ok});
        waitCycles(5);
        pause = 1'b1;
        waitLevel(0, 0, 1'b0, 100, f1, ok);
        checkOutput(32'(f1 - r1));
        waitLevel(0, 0, 1'b1, 5000, r2, ok);
        checkOutput({31'b0, ok});
        pause = 1'b0;
        expectPush("t5_resume_seen", 32'd1);
        expectPush("t5_phase_kept", 32'd1);
        waitRise(0, 4500, r1, ok);
        checkOutput({31'b0, ok});
        waitCycles(1920);
        pause = 1'b1;
        p0 = cyc;
        waitCycles(3000);
        pause = 1'b0;
        p1 = cyc;
        waitRise(0, 5000, r2, ok);
        delta = r2 - r1 - (p1 - p0);
        checkOutput({31'b0, ok && (delta >= 3720) && (delta <= 3960)});

        $display("[TB] fault interlock and sticky status");
        applyStimulus(8'h03, 1'b0, 32'h08);
        waitCycles(2);
        expectPush("t6_en1_on", 32'd1);
        checkOutput({31'b0, en[1]});
        @(negedge clk_12MHz);
        fault[1] = 1'b1;
        @(negedge clk_12MHz);
        fault[1] = 1'b0;
        waitCycles(2);
        expectPush("t6_en1_off", 32'd0);
        checkOutput({31'b0, en[1]});
        busRead(8'hF0, 3'd2, 32'h0000_0002, "t6_status_sticky");
        waitCycles(20);
        expectPush("t6_en1_stays_off", 32'd0);
        checkOutput({31'b0, en[1]});
        applyStimulus(8'hF0, 1'b0, 32'h0000_0002);
        waitCycles(2);
        expectPush("t6_en1_back", 32'd1);
        checkOutput({31'b0, en[1]});
        busRead(8'hF0, 3'd2, 32'h0, "t6_status_clear");
        @(negedge clk_12MHz);
        fault[1] = 1'b1;
        @(negedge clk_12MHz);
        fault[1] = 1'b0;
        applyStimulus(8'hF0, 1'b0, 32'h0000_0002);
        busRead(8'hF0, 3'd2, 32'h0000_0002, "t6_set_wins");
        expectPush("t6_en1_off_again", 32'd0);
        checkOutput({31'b0, en[1]});

        $display("[TB] reset during a pulse");
        expectPush("t7_rise_seen", 32'd1);
        expectPush("t7_step", 32'h0);
        expectPush("t7_en", 32'h0);
        expectPush("t7_dir", 32'h0);
        expectPush("t7_microstep", 32'h0);
        waitRise(0, 4500, r1, ok);
        checkOutput({31'b0, ok});
        waitCycles(3);
        reset = 1'b1;
        @(negedge clk_12MHz);
        checkOutput(32'(step));
        checkOutput(32'(en));
        checkOutput(32'(dir));
        checkOutput(32'(microstep));
        reset = 1'b0;
        busRead(8'h00, 3'd1, 32'd127, "t7_speed0");
        busRead(8'h05, 3'd1, 32'd0, "t7_mode2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
